display_scan_generator: RTL

Parametrised successor to the per-field display value generator. It owns the digit scan: a prescaler steps through every 7-segment digit position, and the block emits one registered digit code per position. Codes cover 24/12-hour formatting, hyphen fields, leading-zero blanking and a blink for the field being edited. It sits between the time-keeping datapath and the seven-segment decoder/anode driver.

---
 rtl/display_scan_generator.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/display_scan_generator.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_generator
// Purpose  : Owns the 7-segment digit scan. A prescaler steps through every
//            digit position (highest first). On each step one registered
//            4-bit digit code is emitted for the new position. Codes cover
//            24/12-hour formatting with A/P, hyphens for invalid fields,
//            leading-zero blanking of the hour and a blink for the field
//            being edited.
// Ports    : clk, rst_n (async assert, active-low)
//            display_mode  0 = 24-hour, 1 = 12-hour
//            out_time      packed fields, field k at [k*FIELD_W +: FIELD_W]
//            blank_lz      blank a zero tens digit of the displayed hour
//            edit_en       blink enable
//            edit_sel      display field position to blink
//            digit_idx     digit position (2k+1 tens, 2k ones of field k)
//            digit_code    0-9, 10 = A, 11 = P, 12 = hyphen, 15 = off
//            frame_start   pulse when digit_idx becomes 2*FIELDS-1
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_generator #(
    parameter int FIELDS       = 3,
    parameter int FIELD_W      = 7,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64,
    parameter int IDX_W        = $clog2(2*FIELDS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      display_mode,
    input  logic [FIELDS*FIELD_W-1:0] out_time,
    input  logic                      blank_lz,
    input  logic                      edit_en,
    input  logic [IDX_W-1:0]          edit_sel,
    output logic [IDX_W-1:0]          digit_idx,
    output logic [3:0]                digit_code,
    output logic                      frame_start
);

    localparam int c_PRE_W = $clog2(SCAN_DIV);
    localparam int c_BLK_W = $clog2(BLINK_FRAMES + 1);
    // Arithmetic width: wide enough to hold 99 even for narrow fields.
    localparam int c_VW    = (FIELD_W > 7) ? FIELD_W : 7;

    localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(2*FIELDS - 1);
    localparam logic [IDX_W-1:0]   c_HOUR_D   = IDX_W'(FIELDS - 1);
    localparam logic [FIELD_W-1:0] c_ALL_ONES = '1;
    localparam logic [3:0] c_CODE_A    = 4'd10;
    localparam logic [3:0] c_CODE_P    = 4'd11;
    localparam logic [3:0] c_CODE_HYPH = 4'd12;
    localparam logic [3:0] c_CODE_OFF  = 4'd15;

    logic [c_PRE_W-1:0] r_presc;
    logic               w_tick;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_frame_evt;

    logic               r_phase;
    logic [c_BLK_W-1:0] r_bcnt;
    logic               r_edit_en_d;
    logic [IDX_W-1:0]   r_edit_sel_d;
    logic               w_clear;
    logic               w_phase_nxt;
    logic [c_BLK_W-1:0] w_bcnt_nxt;

    logic [FIELD_W-1:0] w_field [FIELDS];
    logic [IDX_W-1:0]   w_d;
    logic               w_is_tens;
    logic [IDX_W-1:0]   w_src_sel;
    logic [FIELD_W-1:0] w_src_raw;
    logic               w_src_is_hour;
    logic               w_src_bad;
    logic [c_VW-1:0]    w_v;
    logic [3:0]         w_tens;
    logic [3:0]         w_ones;
    logic               w_hour_bad;
    logic               w_hour_pm;
    logic               w_ap_pos;
    logic               w_blink;
    logic [3:0]         w_code;

    genvar k;
    generate
        for (k = 0; k < FIELDS; k++) begin : g_fields
            assign w_field[k] = out_time[k*FIELD_W +: FIELD_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scan sequencing
    // ------------------------------------------------------------------
    assign w_tick      = (r_presc == c_PRE_W'(SCAN_DIV - 1));
    assign w_idx_nxt   = (digit_idx == '0) ? c_LAST_IDX : digit_idx - 1'b1;
    assign w_frame_evt = w_tick && (digit_idx == '0);

    // ------------------------------------------------------------------
    // Blink state. The next-state phase is what the code for the new
    // digit uses, so a frame boundary switches the whole frame at once.
    // The counter holds 0 right after a clear; the partial frame in which
    // editing started is therefore not counted toward the first half-period.
    // ------------------------------------------------------------------
    assign w_clear = (edit_en && !r_edit_en_d) || (edit_sel != r_edit_sel_d);

    always_comb begin
        w_phase_nxt = r_phase;
        w_bcnt_nxt  = r_bcnt;
        if (w_clear || !edit_en) begin
            w_phase_nxt = 1'b0;
            w_bcnt_nxt  = '0;
        end else if (w_frame_evt) begin
            if (r_bcnt == c_BLK_W'(BLINK_FRAMES)) begin
                w_phase_nxt = ~r_phase;
                w_bcnt_nxt  = c_BLK_W'(1);
            end else begin
                w_bcnt_nxt  = r_bcnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit code for the position about to be displayed
    // ------------------------------------------------------------------
    assign w_d       = w_idx_nxt >> 1;
    assign w_is_tens = w_idx_nxt[0];
    // In 12-hour mode every display field shows the next source field up.
    assign w_src_sel     = display_mode ? (w_d + 1'b1) : w_d;
    assign w_src_is_hour = (w_src_sel == c_HOUR_D);
    assign w_ap_pos      = display_mode && (w_d == c_HOUR_D);

    assign w_hour_bad = (w_field[FIELDS-1] == c_ALL_ONES) ||
                        (c_VW'(w_field[FIELDS-1]) > c_VW'(99));
    assign w_hour_pm  = (c_VW'(w_field[FIELDS-1]) >= c_VW'(12));

    always_comb begin
        w_src_raw = '0;
        for (int i = 0; i < FIELDS; i++) begin
            if (w_src_sel == IDX_W'(i)) begin
                w_src_raw = w_field[i];
            end
        end
    end

    assign w_src_bad = (w_src_raw == c_ALL_ONES) || (c_VW'(w_src_raw) > c_VW'(99));

    always_comb begin
        w_v = c_VW'(w_src_raw);
        if (display_mode && w_src_is_hour) begin
            if (w_src_raw == '0) begin
                w_v = c_VW'(12);
            end else if ((w_v >= c_VW'(13)) && (w_v <= c_VW'(23))) begin
                w_v = w_v - c_VW'(12);
            end
        end
    end

    assign w_tens  = 4'(w_v / c_VW'(10));
    assign w_ones  = 4'(w_v % c_VW'(10));
    assign w_blink = edit_en && (edit_sel == w_d) && w_phase_nxt;

    always_comb begin
        w_code = w_is_tens ? w_tens : w_ones;
        if (w_blink) begin
            w_code = c_CODE_OFF;
        end else if (w_ap_pos) begin
            if (w_hour_bad) begin
                w_code = c_CODE_HYPH;
            end else if (w_is_tens) begin
                w_code = w_hour_pm ? c_CODE_P : c_CODE_A;
            end else begin
                w_code = c_CODE_OFF;
            end
        end else if (w_src_bad) begin
            w_code = c_CODE_HYPH;
        end else if (blank_lz && w_is_tens && w_src_is_hour && (w_tens == 4'd0)) begin
            w_code = c_CODE_OFF;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            digit_idx    <= '0;
            digit_code   <= c_CODE_OFF;
            frame_start  <= 1'b0;
            r_phase      <= 1'b0;
            r_bcnt       <= '0;
            r_edit_en_d  <= 1'b0;
            r_edit_sel_d <= '0;
        end else begin
            r_presc      <= w_tick ? '0 : r_presc + 1'b1;
            frame_start  <= w_frame_evt;
            r_phase      <= w_phase_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_edit_en_d  <= edit_en;
            r_edit_sel_d <= edit_sel;
            if (w_tick) begin
                digit_idx  <= w_idx_nxt;
                digit_code <= w_code;
            end
        end
    end

endmodule
`default_nettype wire
